apb_onread_reg_block: RTL and testbench

- APB3 slave register block with three 32-bit software-readable/writable registers.
- Each register exercises one software read side-effect: none, read-clear, or read-set.
- Each field also has a hardware load port (value plus pulse) and a current-value output.
- Sits between the system APB bus and hardware logic. Also provides a slave-error interrupt with clear, and a software-triggered global synchronous reset output.

---
 rtl/apb_onread_reg_block_if.sv | 25 ++
 rtl/apb_onread_reg_block.sv | 135 +++++++++++++
 tb/tb_apb_onread_reg_block.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_onread_reg_block_if.sv
// APB3 bus bundle between the system bus master and the on-read register block.
// Master drives the request side; the slave returns PREADY, PRDATA and PSLVERR.
interface apb_onread_reg_block_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 32
);
   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic                  PREADY;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PREADY, PRDATA, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PREADY, PRDATA, PSLVERR
   );
endinterface

// File: rtl/apb_onread_reg_block.sv
// APB3 slave with three registers (no side-effect, read-clear, read-set), hardware load
// ports, sticky slave-error interrupt and a software-triggered one-cycle sync reset pulse.
module apb_onread_reg_block #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rstn,
   apb_onread_reg_block_if.slave apb,
   output logic                  interrupt,
   input  logic                  clear,
   output logic                  global_sync_reset_out,
   input  logic [DATA_WIDTH-1:0] REG1_ONREAD_NA__FIELD_0__next_value,
   input  logic                  REG1_ONREAD_NA__FIELD_0__pulse,
   output logic [DATA_WIDTH-1:0] REG1_ONREAD_NA__FIELD_0__curr_value,
   input  logic [DATA_WIDTH-1:0] REG2_ONREAD_RCLR__FIELD_0__next_value,
   input  logic                  REG2_ONREAD_RCLR__FIELD_0__pulse,
   output logic [DATA_WIDTH-1:0] REG2_ONREAD_RCLR__FIELD_0__curr_value,
   input  logic [DATA_WIDTH-1:0] REG3_ONREAD_RSET__FIELD_0__next_value,
   input  logic                  REG3_ONREAD_RSET__FIELD_0__pulse,
   output logic [DATA_WIDTH-1:0] REG3_ONREAD_RSET__FIELD_0__curr_value
);

   localparam logic [ADDR_WIDTH-1:0] L_ADDR_REG1 = ADDR_WIDTH'('h0);
   localparam logic [ADDR_WIDTH-1:0] L_ADDR_REG2 = ADDR_WIDTH'('h4);
   localparam logic [ADDR_WIDTH-1:0] L_ADDR_REG3 = ADDR_WIDTH'('h8);
   localparam logic [ADDR_WIDTH-1:0] L_ADDR_CTRL = ADDR_WIDTH'('hC);

   typedef enum logic {S_IDLE, S_READY} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_pready;
   logic [DATA_WIDTH-1:0] r_reg1;
   logic [DATA_WIDTH-1:0] r_reg2;
   logic [DATA_WIDTH-1:0] r_reg3;
   logic                  r_gsr;
   logic                  r_irq;
   logic                  w_hit1, w_hit2, w_hit3, w_hitc, w_unmapped;
   logic                  w_complete, w_wr, w_rd;
   logic [DATA_WIDTH-1:0] w_rdata;

   // Priority: global sync reset, then software access, then hardware load.
   function automatic logic [DATA_WIDTH-1:0] f_field_next(
      input logic [DATA_WIDTH-1:0] cur,
      input logic                  gsr,
      input logic                  sw_wr,
      input logic [DATA_WIDTH-1:0] wdata,
      input logic                  sw_rd_se,
      input logic [DATA_WIDTH-1:0] rd_val,
      input logic                  hw_pulse,
      input logic [DATA_WIDTH-1:0] hw_val
   );
      if (gsr)           return '0;
      else if (sw_wr)    return wdata;
      else if (sw_rd_se) return rd_val;
      else if (hw_pulse) return hw_val;
      else               return cur;
   endfunction

   assign w_hit1     = (apb.PADDR == L_ADDR_REG1);
   assign w_hit2     = (apb.PADDR == L_ADDR_REG2);
   assign w_hit3     = (apb.PADDR == L_ADDR_REG3);
   assign w_hitc     = (apb.PADDR == L_ADDR_CTRL);
   assign w_unmapped = ~(w_hit1 | w_hit2 | w_hit3 | w_hitc);

   // A transfer only completes if the master still holds PSEL/PENABLE in the PREADY cycle.
   assign w_complete = w_pready & apb.PSEL & apb.PENABLE;
   assign w_wr       = w_complete & apb.PWRITE;
   assign w_rd       = w_complete & ~apb.PWRITE;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (apb.PSEL && apb.PENABLE) w_state_nxt = S_READY;
         S_READY: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_pready = (r_state == S_READY);
   end

   always_comb begin
      w_rdata = '0;
      if (w_pready && !apb.PWRITE) begin
         if (w_hit1)      w_rdata = r_reg1;
         else if (w_hit2) w_rdata = r_reg2;
         else if (w_hit3) w_rdata = r_reg3;
      end
   end

   assign apb.PREADY  = w_pready;
   assign apb.PRDATA  = w_rdata;
   assign apb.PSLVERR = w_pready & w_unmapped;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_reg1 <= '0;
         r_reg2 <= '0;
         r_reg3 <= '0;
      end else begin
         r_reg1 <= f_field_next(r_reg1, r_gsr, w_wr & w_hit1, apb.PWDATA, 1'b0, '0,
                                REG1_ONREAD_NA__FIELD_0__pulse, REG1_ONREAD_NA__FIELD_0__next_value);
         r_reg2 <= f_field_next(r_reg2, r_gsr, w_wr & w_hit2, apb.PWDATA, w_rd & w_hit2, '0,
                                REG2_ONREAD_RCLR__FIELD_0__pulse, REG2_ONREAD_RCLR__FIELD_0__next_value);
         r_reg3 <= f_field_next(r_reg3, r_gsr, w_wr & w_hit3, apb.PWDATA, w_rd & w_hit3, '1,
                                REG3_ONREAD_RSET__FIELD_0__pulse, REG3_ONREAD_RSET__FIELD_0__next_value);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_gsr <= 1'b0;
         r_irq <= 1'b0;
      end else begin
         r_gsr <= w_wr & w_hitc & apb.PWDATA[0];
         if (w_complete && w_unmapped) r_irq <= 1'b1;
         else if (clear)               r_irq <= 1'b0;
      end
   end

   assign interrupt                            = r_irq;
   assign global_sync_reset_out                = r_gsr;
   assign REG1_ONREAD_NA__FIELD_0__curr_value   = r_reg1;
   assign REG2_ONREAD_RCLR__FIELD_0__curr_value = r_reg2;
   assign REG3_ONREAD_RSET__FIELD_0__curr_value = r_reg3;

endmodule

// File: tb/tb_apb_onread_reg_block.sv
// Directed bench for apb_onread_reg_block: register side-effects, hardware loads,
// slave-error interrupt, abandoned transfers and the software sync reset pulse.
module tb_apb_onread_reg_block;
   logic        clk;
   logic        rstn;
   logic        interrupt;
   logic        clear;
   logic        gsr;
   logic [31:0] r1_nv, r2_nv, r3_nv;
   logic        r1_p, r2_p, r3_p;
   logic [31:0] r1_cv, r2_cv, r3_cv;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] rd;
   logic        err;
   logic        pre;
   int          waits;

   apb_onread_reg_block_if #(.ADDR_WIDTH(64), .DATA_WIDTH(32)) apb_if ();

   apb_onread_reg_block #(.ADDR_WIDTH(64), .DATA_WIDTH(32)) dut (
      .clk                                   (clk),
      .rstn                                  (rstn),
      .apb                                   (apb_if),
      .interrupt                             (interrupt),
      .clear                                 (clear),
      .global_sync_reset_out                 (gsr),
      .REG1_ONREAD_NA__FIELD_0__next_value   (r1_nv),
      .REG1_ONREAD_NA__FIELD_0__pulse        (r1_p),
      .REG1_ONREAD_NA__FIELD_0__curr_value   (r1_cv),
      .REG2_ONREAD_RCLR__FIELD_0__next_value (r2_nv),
      .REG2_ONREAD_RCLR__FIELD_0__pulse      (r2_p),
      .REG2_ONREAD_RCLR__FIELD_0__curr_value (r2_cv),
      .REG3_ONREAD_RSET__FIELD_0__next_value (r3_nv),
      .REG3_ONREAD_RSET__FIELD_0__pulse      (r3_p),
      .REG3_ONREAD_RSET__FIELD_0__curr_value (r3_cv)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   // Full APB transfer; optional REG2 hw pulse lands on the completing edge.
   task automatic apb_xfer(input bit wr, input logic [63:0] addr, input logic [31:0] wd,
                           input bit pulse2, output logic [31:0] o_rd, output logic o_err,
                           output logic o_pre, output int o_waits);
      int n;
      @(negedge clk);
      apb_if.PSEL = 1'b1; apb_if.PENABLE = 1'b0;
      apb_if.PWRITE = wr; apb_if.PADDR = addr; apb_if.PWDATA = wd;
      @(negedge clk);
      apb_if.PENABLE = 1'b1;
      #1 o_pre = apb_if.PREADY;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!apb_if.PREADY && n < 8);
      if (!apb_if.PREADY) chk_eq("pready_timeout", 64'(apb_if.PREADY), 64'd1);
      o_waits = n;
      o_rd    = apb_if.PRDATA;
      o_err   = apb_if.PSLVERR;
      if (pulse2) begin
         r2_nv = 32'h1234_5678;
         r2_p  = 1'b1;
      end
      @(negedge clk);
      apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0;
      r2_p = 1'b0;
   endtask

   initial begin
      rstn = 1'b0; clear = 1'b0;
      r1_nv = '0; r2_nv = '0; r3_nv = '0;
      r1_p = 1'b0; r2_p = 1'b0; r3_p = 1'b0;
      apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b0;
      apb_if.PADDR = '0; apb_if.PWDATA = '0;
      repeat (3) @(negedge clk);
      chk_eq("rst_reg1", r1_cv, 0);
      chk_eq("rst_reg2", r2_cv, 0);
      chk_eq("rst_reg3", r3_cv, 0);
      chk_eq("rst_irq", interrupt, 0);
      chk_eq("rst_pready", apb_if.PREADY, 0);
      chk_eq("rst_pslverr", apb_if.PSLVERR, 0);
      chk_eq("rst_prdata", apb_if.PRDATA, 0);
      chk_eq("rst_gsr", gsr, 0);
      rstn = 1'b1;
      @(negedge clk);

      // REG1: no read side-effect
      apb_xfer(1, 64'h0, 32'h0, 0, rd, err, pre, waits);
      chk_eq("r1_wr0_curr", r1_cv, 32'h0);
      chk_eq("wait_state_pready0", pre, 0);
      chk_eq("wait_state_count", waits, 1);
      apb_xfer(0, 64'h0, 32'h0, 0, rd, err, pre, waits);
      chk_eq("r1_rd0_data", rd, 32'h0);
      chk_eq("r1_rd0_curr", r1_cv, 32'h0);
      apb_xfer(1, 64'h0, 32'hFFFF_FFFF, 0, rd, err, pre, waits);
      chk_eq("r1_wrF_curr", r1_cv, 32'hFFFF_FFFF);
      apb_xfer(0, 64'h0, 32'h0, 0, rd, err, pre, waits);
      chk_eq("r1_rdF_data", rd, 32'hFFFF_FFFF);
      chk_eq("r1_rdF_err", err, 0);
      chk_eq("r1_rdF_curr", r1_cv, 32'hFFFF_FFFF);

      // REG2: read-clear
      apb_xfer(1, 64'h4, 32'hFFFF_FFFF, 0, rd, err, pre, waits);
      chk_eq("r2_wrF_curr", r2_cv, 32'hFFFF_FFFF);
      apb_xfer(0, 64'h4, 32'h0, 0, rd, err, pre, waits);
      chk_eq("r2_rd_data", rd, 32'hFFFF_FFFF);
      chk_eq("r2_rd_curr", r2_cv, 32'h0);
      apb_xfer(0, 64'h4, 32'h0, 0, rd, err, pre, waits);
      chk_eq("r2_rd2_data", rd, 32'h0);

      // REG3: read-set
      apb_xfer(1, 64'h8, 32'h0, 0, rd, err, pre, waits);
      chk_eq("r3_wr0_curr", r3_cv, 32'h0);
      apb_xfer(0, 64'h8, 32'h0, 0, rd, err, pre, waits);
      chk_eq("r3_rd_data", rd, 32'h0);
      chk_eq("r3_rd_curr", r3_cv, 32'hFFFF_FFFF);
      apb_xfer(1, 64'h8, 32'hFFFF_FFFF, 0, rd, err, pre, waits);
      chk_eq("r3_wrF_curr", r3_cv, 32'hFFFF_FFFF);

      // Hardware load, then same-edge conflict with a software write
      @(negedge clk);
      r2_nv = 32'h1234_5678; r2_p = 1'b1;
      @(negedge clk);
      r2_p = 1'b0;
      chk_eq("r2_hw_load", r2_cv, 32'h1234_5678);
      chk_eq("r1_untouched_by_r2_hw", r1_cv, 32'hFFFF_FFFF);
      apb_xfer(1, 64'h4, 32'hA5A5_A5A5, 1, rd, err, pre, waits);
      chk_eq("r2_sw_over_hw", r2_cv, 32'hA5A5_A5A5);

      // Unmapped read: error, zero data, sticky interrupt until clear
      apb_xfer(0, 64'h100, 32'h0, 0, rd, err, pre, waits);
      chk_eq("unm_rd_err", err, 1);
      chk_eq("unm_rd_data", rd, 32'h0);
      chk_eq("unm_irq_set", interrupt, 1);
      chk_eq("unm_no_change_r2", r2_cv, 32'hA5A5_A5A5);
      repeat (2) @(negedge clk);
      chk_eq("irq_sticky", interrupt, 1);
      clear = 1'b1;
      @(negedge clk);
      chk_eq("irq_cleared", interrupt, 0);
      // Error and clear on the same edge: set wins
      apb_xfer(1, 64'h10, 32'h1, 0, rd, err, pre, waits);
      chk_eq("irq_set_wins", interrupt, 1);
      chk_eq("unm_wr_err", err, 1);
      clear = 1'b0;

      // CTRL reads as zero with no error
      apb_xfer(0, 64'hC, 32'h0, 0, rd, err, pre, waits);
      chk_eq("ctrl_rd_data", rd, 32'h0);
      chk_eq("ctrl_rd_err", err, 0);
      chk_eq("ctrl_rd_no_gsr", gsr, 0);

      // Global sync reset overrides a hw pulse in its cycle
      apb_xfer(1, 64'h0, 32'h1111_1111, 0, rd, err, pre, waits);
      apb_xfer(1, 64'hC, 32'h1, 0, rd, err, pre, waits);
      chk_eq("gsr_pulse_high", gsr, 1);
      chk_eq("gsr_r1_before", r1_cv, 32'h1111_1111);
      r1_nv = 32'hDEAD_BEEF; r1_p = 1'b1;
      @(negedge clk);
      r1_p = 1'b0;
      chk_eq("gsr_pulse_low", gsr, 0);
      chk_eq("gsr_r1_zero", r1_cv, 32'h0);
      chk_eq("gsr_r2_zero", r2_cv, 32'h0);
      chk_eq("gsr_r3_zero", r3_cv, 32'h0);

      // Abandoned write: PSEL drops during the PREADY cycle
      @(negedge clk);
      apb_if.PSEL = 1'b1; apb_if.PENABLE = 1'b0;
      apb_if.PWRITE = 1'b1; apb_if.PADDR = 64'h0; apb_if.PWDATA = 32'h2222_2222;
      @(negedge clk);
      apb_if.PENABLE = 1'b1;
      @(negedge clk);
      chk_eq("abandon_pready", apb_if.PREADY, 1);
      apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0;
      @(negedge clk);
      chk_eq("abandon_no_write", r1_cv, 32'h0);
      chk_eq("abandon_pready_low", apb_if.PREADY, 0);
      apb_xfer(0, 64'h0, 32'h0, 0, rd, err, pre, waits);
      chk_eq("after_abandon_rd", rd, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed hang required finish");
      $fatal(1, "timeout");
   end
endmodule
